// File: rtl/imem_if.sv
// Instruction-memory read port: single outstanding request, held until acked.
interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word, holds it until retired, then
// computes the next PC from sequential, branch or jump flow.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_if.master      bus,
    input  logic        retire,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic        instr_valid,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] pc_next, instr_next, retired_cnt_next;
    logic [31:0] pc_plus4, branch_target, jump_target;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        pc_next          = pc;
        instr_next       = instr;
        retired_cnt_next = retired_cnt;
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_next = bus.imem_rdata;
                    pc_next    = fetch_pc;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    // Jump wins over a taken branch when both flags are raised.
                    if (jump)              fetch_pc_next = jump_target;
                    else if (branch_taken) fetch_pc_next = branch_target;
                    else                   fetch_pc_next = pc_plus4;
                    retired_cnt_next = retired_cnt + 32'd1;
                    state_next       = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC_W;
            pc          <= RESET_PC_W;
            instr       <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            pc          <= pc_next;
            instr       <= instr_next;
            retired_cnt <= retired_cnt_next;
        end
    end

    assign bus.imem_req  = (state == FETCH);
    assign bus.imem_addr = {fetch_pc[31:2], 2'b00};
    assign instr_valid   = (state == HOLD);
    assign OpCode        = instr[31:26];
    assign Funct         = instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of fetch/retire transactions,
// fetch-address scoreboard, plus reset-abandon and stray-input sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire, branch_taken, jump;
    logic [31:0] pc, instr, retired_cnt;
    logic [5:0]  OpCode, Funct;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cnt;

    imem_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .retire(retire), .branch_taken(branch_taken), .jump(jump),
        .pc(pc), .instr(instr), .OpCode(OpCode), .Funct(Funct),
        .instr_valid(instr_valid), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          stall;
        logic        jmp;
        logic        br;
        logic [31:0] next_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] rdata, input int stall);
        logic [31:0] a;
        int waited = 0;
        while (bus.imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", {31'd0, bus.imem_req}, 32'd1);
        if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            a = 32'hxxxx_xxxx;
        end else begin
            a = exp_q.pop_front();
        end
        check("fetch_addr", bus.imem_addr, a);
        check("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_req", {31'd0, bus.imem_req}, 32'd1);
            check("stall_addr", bus.imem_addr, a);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        check("req_in_hold", {31'd0, bus.imem_req}, 32'd0);
        check("instr", instr, rdata);
        check("pc", pc, a);
        check("opcode", {26'd0, OpCode}, {26'd0, rdata[31:26]});
        check("funct", {26'd0, Funct}, {26'd0, rdata[5:0]});
    endtask

    task automatic do_retire(input logic j, input logic b, input logic [31:0] next_addr,
                             input logic [31:0] held_instr, input logic [31:0] held_pc);
        // Stray ack plus jump/branch without retire must leave HOLD untouched.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = ~held_instr;
        jump           = 1'b1;
        branch_taken   = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, held_instr);
        check("hold_pc", pc, held_pc);
        check("hold_cnt", retired_cnt, exp_cnt);
        retire       = 1'b1;
        jump         = j;
        branch_taken = b;
        @(negedge clk);
        retire       = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        exp_q.push_back(next_addr);
        exp_cnt++;
        check("retired_cnt", retired_cnt, exp_cnt);
        check("req_next_cycle", {31'd0, bus.imem_req}, 32'd1);
        check("valid_drop", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h3401_0005, 1, 1'b0, 1'b0, 32'h0000_3004};
        vecs[1] = '{32'h0000_0020, 0, 1'b0, 1'b0, 32'h0000_3008};
        vecs[2] = '{32'h1000_FFFF, 0, 1'b0, 1'b1, 32'h0000_3008};
        vecs[3] = '{32'h0800_0C10, 0, 1'b1, 1'b1, 32'h0000_3040};
        vecs[4] = '{32'h1000_0004, 5, 1'b0, 1'b1, 32'h0000_3054};
        vecs[5] = '{32'h1000_0003, 0, 1'b0, 1'b0, 32'h0000_3058};
        vecs[6] = '{32'h0800_0000, 2, 1'b1, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h1000_FFFE, 0, 1'b0, 1'b1, 32'hFFFF_FFFC};
        vecs[8] = '{32'h0000_0020, 0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[9] = '{32'h0BFF_FFFF, 0, 1'b1, 1'b0, 32'h0FFF_FFFC};

        rst_n = 1'b0;
        retire = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
        exp_cnt = 32'd0;
        repeat (3) @(negedge clk);

        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_instr", instr, 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);

        // Leave reset in the IDLE cycle with stray ack/retire present.
        rst_n = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; retire = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0; retire = 1'b0;
        check("idle_to_fetch_req", {31'd0, bus.imem_req}, 32'd1);
        check("idle_stray_instr", instr, 32'd0);
        check("idle_stray_cnt", retired_cnt, 32'd0);
        exp_q.push_back(32'h0000_3000);

        for (int i = 0; i < 10; i++) begin
            do_fetch(vecs[i].rdata, vecs[i].stall);
            do_retire(vecs[i].jmp, vecs[i].br, vecs[i].next_addr, vecs[i].rdata, pc);
        end

        // Reset while a request is outstanding, then a late ack in IDLE.
        check("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("late_ack_instr", instr, 32'd0);
        check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_cnt", retired_cnt, 32'd0);
        exp_q.delete();
        exp_q.push_back(32'h0000_3000);
        exp_cnt = 32'd0;
        do_fetch(32'h3401_0005, 0);
        check("post_rst_opcode", {26'd0, OpCode}, 32'h0000_000D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-006 SHALL have port imem_ack, input, 1 bit: read data valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 SHALL have port retire, input, 1 bit: the decode/execute side has consumed the current instruction.
REQ-009 SHALL have port branch_taken, input, 1 bit: Branch AND Zero from the controller/ALU for the current instruction.
REQ-010 SHALL have port jump, input, 1 bit: the controller jump flag for the current instruction.
REQ-011 SHALL have port pc, output, 32 bits: address of the held instruction.
REQ-012 SHALL have port instr, output, 32 bits: held instruction word.
REQ-013 SHALL have port OpCode, output, 6 bits: instr[31:26], fed to the controller.
REQ-014 SHALL have port Funct, output, 6 bits: instr[5:0], fed to the controller.
REQ-015 SHALL have port instr_valid, output, 1 bit: instr/pc hold a fetched instruction.
REQ-016 SHALL have port retired_cnt, output, 32 bits: count of retired instructions.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH and HOLD; after reset it SHALL be in IDLE.
REQ-018 IDLE SHALL go to FETCH on the next edge unconditionally, with imem_req=0 in IDLE.
REQ-019 FETCH SHALL assert imem_req=1 with imem_addr=fetch_pc held stable until imem_ack; in the ack cycle it SHALL capture imem_rdata into instr and fetch_pc into pc, then go to HOLD.
REQ-020 HOLD SHALL assert instr_valid=1 and imem_req=0 and hold instr/pc until retire=1.
REQ-021 On retire in HOLD, next fetch_pc SHALL be {pc_plus4[31:28], instr[25:0], 2'b00} if jump=1; else pc_plus4 + (sign-extended instr[15:0] << 2) if branch_taken=1; else pc_plus4, where pc_plus4 = pc + 4 (mod 2^32); the FSM SHALL go to FETCH and increment retired_cnt.
REQ-022 jump SHALL take priority over branch_taken when both are 1.
REQ-023 retire, jump and branch_taken SHALL be ignored outside HOLD.
REQ-024 imem_ack SHALL be ignored outside FETCH, including a late ack arriving after reset.
REQ-025 Latency: retire at edge N SHALL give imem_req=1 with the new address in cycle N+1; ack at edge M SHALL give instr_valid=1 in cycle M+1; minimum loop is 2 cycles per instruction.
REQ-026 imem_addr[1:0] SHALL always be 2'b00; all PC arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-027 retired_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 OpCode and Funct SHALL be combinational slices of instr.

Reset
REQ-029 While rst_n=0 at an edge, the block SHALL load pc=RESET_PC, fetch_pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_cnt=0 and state=IDLE.
REQ-030 Reset asserted mid-fetch or mid-hold SHALL abandon the operation; the first request after reset SHALL be to RESET_PC.

Verification
REQ-031 Reset, then ack in the second FETCH cycle with rdata 32'h3401_0005 -> imem_addr=32'h3000, then instr_valid=1, OpCode=6'h0D, pc=32'h3000.
REQ-032 Retire a plain instruction at pc=32'h3000 -> next imem_addr=32'h3004 one cycle later and retired_cnt=1.
REQ-033 Retire beq with offset 16'hFFFF at pc=32'h3008 and branch_taken=1 -> next imem_addr=32'h3008.
REQ-034 Retire instr 32'h0800_0C10 with jump=1 and branch_taken=1 -> next imem_addr=32'h0000_3040.
REQ-035 Stall ack 5 cycles -> imem_req and imem_addr stable throughout; stray ack and retire during HOLD or IDLE -> no state change.
REQ-036 Assert rst_n=0 while imem_req=1, ack in the following IDLE cycle -> ack ignored, instr=0, next request to 32'h3000.
